up_down_counter: RTL and testbench

// - Generic width-parameterised up/down counter with a programmable reset value.
// - Used by game-logic blocks for player lives (2-bit, reset 2) and ship x-position (10-bit, reset 250).
// - Callers gate up_i/down_i with their own bound checks.
// - The counter itself applies only the wrap/saturate rule below.

---
 rtl/up_down_counter.sv | 86 ++++++++
 tb/tb_up_down_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/up_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : up_down_counter
// Purpose  : Width-parameterised up/down counter with a programmable reset
//            value. Simultaneous up and down requests cancel. Arithmetic is
//            unsigned modulo 2^width_p (wrap-around) by default; defining
//            UP_DOWN_COUNTER_SATURATE_EN switches to saturating arithmetic
//            (up holds at all-ones, down holds at zero).
// Ports    : clk_i     - clock, rising-edge active
//            reset_i   - asynchronous active-high reset, loads reset_val_p
//            up_i      - increment request, sampled on rising clk_i
//            down_i    - decrement request, sampled on rising clk_i
//            counter_o - current count, driven directly from the state reg
// Params   : width_p     - counter width in bits (>= 1)
//            reset_val_p - width_p-bit value loaded on reset
// Config   : UP_DOWN_COUNTER_SATURATE_EN (undefined = wrap-around)
// Revision : 1.0 - initial release
// ============================================================================
module up_down_counter #(
    parameter int                 width_p     = 4,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] counter_o
);

    localparam logic [width_p-1:0] c_one = width_p'(1);
    localparam logic [width_p-1:0] c_max = '1;
    localparam logic [width_p-1:0] c_min = '0;

    logic [width_p-1:0] count;
    logic [width_p-1:0] count_next;

    // Next-state arithmetic stays width_p bits wide, so the default build
    // wraps naturally at both ends without any explicit boundary handling.
    always_comb begin
        count_next = count;
        case ({up_i, down_i})
            2'b10: begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                if (count != c_max) begin
                    count_next = count + c_one;
                end
`else
                count_next = count + c_one;
`endif
            end
            2'b01: begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                if (count != c_min) begin
                    count_next = count - c_one;
                end
`else
                count_next = count - c_one;
`endif
            end
            default: count_next = count;  // idle, or both requests cancel
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= reset_val_p;
        end else begin
            count <= count_next;
        end
    end

    assign counter_o = count;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        assert (width_p >= 1)
            else $error("up_down_counter: width_p must be >= 1");
        if (!reset_i) begin
            assert (!$isunknown({up_i, down_i}))
                else $error("up_down_counter: up_i/down_i unknown while out of reset");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_down_counter
// Purpose  : Self-checking bench for up_down_counter. Two instances share a
//            clock and reset: a 2-bit counter resetting to 2 and a 10-bit
//            counter resetting to 250. Expected counts come from a small
//            reference model and travel through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_down_counter;

`ifdef UP_DOWN_COUNTER_SATURATE_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       up2, down2, up10, down10;
    logic [1:0] cnt2;
    logic [9:0] cnt10;

    up_down_counter #(.width_p(2), .reset_val_p(2'd2)) dut2 (
        .clk_i    (clk),
        .reset_i  (rst),
        .up_i     (up2),
        .down_i   (down2),
        .counter_o(cnt2)
    );

    up_down_counter #(.width_p(10), .reset_val_p(10'd250)) dut10 (
        .clk_i    (clk),
        .reset_i  (rst),
        .up_i     (up10),
        .down_i   (down10),
        .counter_o(cnt10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    exp2;
        int    exp10;
    } exp_t;

    exp_t queue_exp[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m2          = 0;
    int   m10         = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: one clock update of a w-bit counter.
    function automatic int model(input int v, input bit up, input bit dn, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (up && !dn) begin
            if (v == mx) return c_sat ? mx : 0;
            return v + 1;
        end
        if (dn && !up) begin
            if (v == 0) return c_sat ? 0 : mx;
            return v - 1;
        end
        return v;
    endfunction

    // Drive one cycle of requests, push the expected result, then compare
    // the popped expectation just after the sampling edge.
    task automatic step(input string tag, input bit u2, input bit d2, input bit u10, input bit d10);
        exp_t e;
        up2 = u2; down2 = d2; up10 = u10; down10 = d10;
        m2  = model(m2, u2, d2, 2);
        m10 = model(m10, u10, d10, 10);
        e.tag = tag; e.exp2 = m2; e.exp10 = m10;
        queue_exp.push_back(e);
        @(posedge clk);
        #1;
        e = queue_exp.pop_front();
        check({e.tag, "_w2"},  {30'd0, cnt2},  e.exp2);
        check({e.tag, "_w10"}, {22'd0, cnt10}, e.exp10);
    endtask

    // Assert reset mid-cycle with the given up requests held, check the
    // asynchronous load before the next edge, then that it holds across one.
    task automatic rst_pulse(input string tag, input bit u2, input bit u10);
        rst = 1'b1;
        up2 = u2; up10 = u10; down2 = 1'b0; down10 = 1'b0;
        m2 = 2; m10 = 250;
        #2;
        check({tag, "_async_w2"},  {30'd0, cnt2},  32'd2);
        check({tag, "_async_w10"}, {22'd0, cnt10}, 32'd250);
        @(posedge clk);
        #1;
        check({tag, "_hold_w2"},  {30'd0, cnt2},  32'd2);
        check({tag, "_hold_w10"}, {22'd0, cnt10}, 32'd250);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        up2 = 1'b0; down2 = 1'b0; up10 = 1'b0; down10 = 1'b0;
        #2;
        rst_pulse("reset", 1'b1, 1'b1);

        // Count up from 250 to 255, then hold.
        for (int i = 0; i < 5; i++) step("up", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while counting up; counting resumes from the reset value.
        rst_pulse("rst_midrun", 1'b0, 1'b1);
        step("resume", 1'b0, 1'b0, 1'b1, 1'b0);

        // Count down from 250.
        rst_pulse("rst_down", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("down", 1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous requests cancel.
        for (int i = 0; i < 4; i++) step("both", 1'b1, 1'b1, 1'b1, 1'b1);

        // 2-bit top boundary: 2 -> 3, then up at 3.
        step("up_to_max", 1'b1, 1'b0, 1'b0, 1'b0);
        step("up_at_max", 1'b1, 1'b0, 1'b0, 1'b0);
        step("up_after", 1'b1, 1'b0, 1'b0, 1'b0);

        // 2-bit bottom boundary: 2 -> 1 -> 0, then down at 0.
        rst_pulse("rst_bottom", 1'b0, 1'b0);
        step("down_to_1", 1'b0, 1'b1, 1'b0, 1'b0);
        step("down_to_0", 1'b0, 1'b1, 1'b0, 1'b0);
        step("down_at_0", 1'b0, 1'b1, 1'b0, 1'b0);
        step("down_after", 1'b0, 1'b1, 1'b0, 1'b0);

        // 10-bit top boundary: 1023 is reached from 250 only via many steps.
        for (int i = 0; i < 773; i++) step("up10_run", 1'b0, 1'b0, 1'b1, 1'b0);
        step("up10_at_max", 1'b0, 1'b0, 1'b1, 1'b0);

        if (queue_exp.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", queue_exp.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
